nf10_upb_axis_rr_arbiter: RTL and testbench

NF10_UPB_AXIS_RR_ARBITER -- requirements
Module: nf10_upb_axis_rr_arbiter

---
 rtl/nf10_upb_axis_rr_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_nf10_upb_axis_rr_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf10_upb_axis_rr_arbiter.sv
// Four-input AXI-Stream packet arbiter with round-robin selection.
// A granted input keeps the shared output until its tlast beat is accepted;
// the output stage is a single register slice that still sustains one beat
// per cycle when the downstream side is ready.
module nf10_upb_axis_rr_arbiter #(
    parameter int axis_data_width  = 256,
    parameter int axis_tkeep_width = 32,
    parameter int axis_tuser_width = 128
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        s0_axis_tvalid,
    output logic                        s0_axis_tready,
    input  logic [axis_data_width-1:0]  s0_axis_tdata,
    input  logic [axis_tkeep_width-1:0] s0_axis_tkeep,
    input  logic                        s0_axis_tlast,
    input  logic [axis_tuser_width-1:0] s0_axis_tuser,

    input  logic                        s1_axis_tvalid,
    output logic                        s1_axis_tready,
    input  logic [axis_data_width-1:0]  s1_axis_tdata,
    input  logic [axis_tkeep_width-1:0] s1_axis_tkeep,
    input  logic                        s1_axis_tlast,
    input  logic [axis_tuser_width-1:0] s1_axis_tuser,

    input  logic                        s2_axis_tvalid,
    output logic                        s2_axis_tready,
    input  logic [axis_data_width-1:0]  s2_axis_tdata,
    input  logic [axis_tkeep_width-1:0] s2_axis_tkeep,
    input  logic                        s2_axis_tlast,
    input  logic [axis_tuser_width-1:0] s2_axis_tuser,

    input  logic                        s3_axis_tvalid,
    output logic                        s3_axis_tready,
    input  logic [axis_data_width-1:0]  s3_axis_tdata,
    input  logic [axis_tkeep_width-1:0] s3_axis_tkeep,
    input  logic                        s3_axis_tlast,
    input  logic [axis_tuser_width-1:0] s3_axis_tuser,

    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [axis_data_width-1:0]  m_axis_tdata,
    output logic [axis_tkeep_width-1:0] m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic [axis_tuser_width-1:0] m_axis_tuser,

    output logic [1:0]                  grant,
    output logic                        busy,
    output logic [31:0]                 pkt_count
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // First requester after 'last', wrapping 3->0; 'last' itself is
    // examined at the end so a lone repeat requester is granted again.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    state_t                        state_r;
    state_t                        state_nxt_s;
    logic [1:0]                    grant_r;
    logic [1:0]                    grant_nxt_s;

    logic                          m_valid_r;
    logic [axis_data_width-1:0]    m_data_r;
    logic [axis_tkeep_width-1:0]   m_keep_r;
    logic                          m_last_r;
    logic [axis_tuser_width-1:0]   m_user_r;
    logic [31:0]                   pkt_count_r;

    logic [3:0]                    in_valid_s;
    logic [3:0]                    in_last_s;
    logic [axis_data_width-1:0]    in_data_s [4];
    logic [axis_tkeep_width-1:0]   in_keep_s [4];
    logic [axis_tuser_width-1:0]   in_user_s [4];

    logic                          out_free_s;
    logic                          in_xfer_s;
    logic [3:0]                    ready_vec_s;

    assign in_valid_s = {s3_axis_tvalid, s2_axis_tvalid, s1_axis_tvalid, s0_axis_tvalid};
    assign in_last_s  = {s3_axis_tlast,  s2_axis_tlast,  s1_axis_tlast,  s0_axis_tlast};

    assign in_data_s[0] = s0_axis_tdata;
    assign in_data_s[1] = s1_axis_tdata;
    assign in_data_s[2] = s2_axis_tdata;
    assign in_data_s[3] = s3_axis_tdata;
    assign in_keep_s[0] = s0_axis_tkeep;
    assign in_keep_s[1] = s1_axis_tkeep;
    assign in_keep_s[2] = s2_axis_tkeep;
    assign in_keep_s[3] = s3_axis_tkeep;
    assign in_user_s[0] = s0_axis_tuser;
    assign in_user_s[1] = s1_axis_tuser;
    assign in_user_s[2] = s2_axis_tuser;
    assign in_user_s[3] = s3_axis_tuser;

    // The output slice can take a beat when empty or being drained this cycle.
    assign out_free_s = !m_valid_r || m_axis_tready;
    assign in_xfer_s  = (state_r == ST_LOCKED) && in_valid_s[grant_r] && out_free_s;

    // Next-state and grant selection: arbitrate only in IDLE, release on tlast.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        case (state_r)
            ST_IDLE: begin
                if (|in_valid_s) begin
                    state_nxt_s = ST_LOCKED;
                    grant_nxt_s = rr_pick(in_valid_s, grant_r);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (in_xfer_s && in_last_s[grant_r]) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = grant_r;
            end
        endcase
    end

    // Only the granted input sees ready, and only while the FSM is locked.
    always_comb begin
        ready_vec_s = 4'b0000;
        if (state_r == ST_LOCKED) begin
            ready_vec_s[grant_r] = out_free_s;
        end else begin
            ready_vec_s = 4'b0000;
        end
    end

    assign s0_axis_tready = ready_vec_s[0];
    assign s1_axis_tready = ready_vec_s[1];
    assign s2_axis_tready = ready_vec_s[2];
    assign s3_axis_tready = ready_vec_s[3];

    // FSM state and round-robin pointer; grant 3 makes input 0 win first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            grant_r <= 2'd3;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
        end
    end

    // Output register slice: load on input transfer, empty on drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            m_keep_r  <= '0;
            m_last_r  <= 1'b0;
            m_user_r  <= '0;
        end else if (in_xfer_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= in_data_s[grant_r];
            m_keep_r  <= in_keep_s[grant_r];
            m_last_r  <= in_last_s[grant_r];
            m_user_r  <= in_user_s[grant_r];
        end else if (m_valid_r && m_axis_tready) begin
            m_valid_r <= 1'b0;
        end
    end

    // Packet counter: one count per accepted output beat carrying tlast, wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_r <= 32'd0;
        end else if (m_valid_r && m_axis_tready && m_last_r) begin
            pkt_count_r <= pkt_count_r + 32'd1;
        end
    end

    assign m_axis_tvalid = m_valid_r;
    assign m_axis_tdata  = m_data_r;
    assign m_axis_tkeep  = m_keep_r;
    assign m_axis_tlast  = m_last_r;
    assign m_axis_tuser  = m_user_r;
    assign grant         = grant_r;
    assign busy          = (state_r == ST_LOCKED);
    assign pkt_count     = pkt_count_r;

endmodule

// File: tb/tb_nf10_upb_axis_rr_arbiter.sv
// Scoreboard bench for the four-input round-robin AXI-Stream arbiter.
// Packets are queued per source and, in the order the arbiter is expected
// to serve them, on one expected-beat queue; a monitor pops and compares.
module tb_nf10_upb_axis_rr_arbiter;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
        logic [127:0] user;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         s_valid [4];
    logic         s_ready [4];
    logic [255:0] s_data  [4];
    logic [31:0]  s_keep  [4];
    logic         s_last  [4];
    logic [127:0] s_user  [4];
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic         m_axis_tlast;
    logic [127:0] m_axis_tuser;
    logic [1:0]   grant;
    logic         busy;
    logic [31:0]  pkt_count;

    beat_t        src_q [4][$];
    beat_t        exp_q [$];
    int           exp_grant [$];
    bit           fired [4];
    logic         m_ready_want = 1'b1;
    logic         prev_busy = 1'b0;
    int           cyc = 0;
    int           last_rise = -1;
    bit           period_chk = 1'b0;
    int           pkt_id = 0;
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    nf10_upb_axis_rr_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .s0_axis_tvalid (s_valid[0]), .s0_axis_tready (s_ready[0]),
        .s0_axis_tdata  (s_data[0]),  .s0_axis_tkeep  (s_keep[0]),
        .s0_axis_tlast  (s_last[0]),  .s0_axis_tuser  (s_user[0]),
        .s1_axis_tvalid (s_valid[1]), .s1_axis_tready (s_ready[1]),
        .s1_axis_tdata  (s_data[1]),  .s1_axis_tkeep  (s_keep[1]),
        .s1_axis_tlast  (s_last[1]),  .s1_axis_tuser  (s_user[1]),
        .s2_axis_tvalid (s_valid[2]), .s2_axis_tready (s_ready[2]),
        .s2_axis_tdata  (s_data[2]),  .s2_axis_tkeep  (s_keep[2]),
        .s2_axis_tlast  (s_last[2]),  .s2_axis_tuser  (s_user[2]),
        .s3_axis_tvalid (s_valid[3]), .s3_axis_tready (s_ready[3]),
        .s3_axis_tdata  (s_data[3]),  .s3_axis_tkeep  (s_keep[3]),
        .s3_axis_tlast  (s_last[3]),  .s3_axis_tuser  (s_user[3]),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .grant          (grant),
        .busy           (busy),
        .pkt_count      (pkt_count)
    );

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Queue one packet on a source and append its beats to the expected stream.
    task automatic push_pkt(input int src, input int nbeats);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data = {8{8'(src), 8'(pkt_id), 8'(i), 8'hA5}};
            b.keep = (i == nbeats - 1) ? (32'hFFFF_FFFF >> i) : 32'hFFFF_FFFF;
            b.last = (i == nbeats - 1);
            b.user = {4{8'(pkt_id), 8'(src), 16'(i)}};
            src_q[src].push_back(b);
            exp_q.push_back(b);
        end
        pkt_id++;
    endtask

    task automatic flush_all();
        for (int n = 0; n < 4; n++) src_q[n].delete();
        exp_q.delete();
        exp_grant.delete();
    endtask

    function automatic bit all_empty();
        return (exp_q.size() == 0) && (src_q[0].size() == 0) && (src_q[1].size() == 0)
            && (src_q[2].size() == 0) && (src_q[3].size() == 0);
    endfunction

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!all_empty() && k < budget) begin
            @(negedge clk); #2;
            k++;
        end
        if (k >= budget) check_val({tag, "_timeout"}, 1, 0);
        repeat (3) @(negedge clk);
        #2;
        check_val({tag, "_grants_left"}, exp_grant.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_m_valid"}, m_axis_tvalid, 1'b0);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_grant"}, grant, 2'd3);
        check_val({tag, "_pkt_count"}, pkt_count, 32'd0);
        check_val({tag, "_ready"}, {s_ready[3], s_ready[2], s_ready[1], s_ready[0]}, 4'b0000);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        reset = 1'b1;
        flush_all();
        repeat (2) @(negedge clk);
        #2;
        check_reset_state("rst");
        reset = 1'b0;
    endtask

    // Source drivers plus output/grant monitor, all paced by the falling edge.
    initial begin : drv
        beat_t h;
        beat_t e;
        for (int n = 0; n < 4; n++) begin
            s_valid[n] = 1'b0; s_data[n] = '0; s_keep[n] = '0; s_last[n] = 1'b0; s_user[n] = '0;
        end
        m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            for (int n = 0; n < 4; n++) begin
                if (fired[n] && src_q[n].size() > 0) void'(src_q[n].pop_front());
                fired[n] = 1'b0;
                if (src_q[n].size() > 0) begin
                    h = src_q[n][0];
                    s_valid[n] = 1'b1;
                    s_data[n]  = h.data;
                    s_keep[n]  = h.keep;
                    s_last[n]  = h.last;
                    s_user[n]  = h.user;
                end else begin
                    s_valid[n] = 1'b0;
                end
            end
            m_axis_tready = m_ready_want;
            #1;
            for (int n = 0; n < 4; n++) fired[n] = s_valid[n] && s_ready[n];
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("tdata", m_axis_tdata, e.data);
                    check_val("tkeep", m_axis_tkeep, e.keep);
                    check_val("tlast", m_axis_tlast, e.last);
                    check_val("tuser", m_axis_tuser, e.user);
                end
            end
            if (busy && !prev_busy) begin
                if (exp_grant.size() == 0) begin
                    check_val("unexpected_grant", 1, 0);
                end else begin
                    check_val("grant_seq", grant, exp_grant.pop_front());
                end
                if (period_chk && last_rise >= 0) check_val("grant_period", cyc - last_rise, 2);
                last_rise = cyc;
            end
            prev_busy = busy;
        end
    end

    // Test sequence.
    initial begin : seq
        int k;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check_reset_state("init");
        reset = 1'b0;

        // s0 and s2 contend with 3-beat packets: s0 first, then s2.
        push_pkt(0, 3);
        push_pkt(2, 3);
        exp_grant.push_back(0);
        exp_grant.push_back(2);
        wait_done("two_src", 100);
        check_val("two_src_pkt_count", pkt_count, 32'd2);
        check_val("two_src_grant_kept", grant, 2'd2);
        check_val("two_src_idle", busy, 1'b0);

        // All four inputs continuously valid with 1-beat packets.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int n = 0; n < 4; n++) begin
                push_pkt(n, 1);
                exp_grant.push_back(n);
            end
        end
        period_chk = 1'b1;
        last_rise  = -1;
        wait_done("all_four", 100);
        period_chk = 1'b0;
        check_val("all_four_pkt_count", pkt_count, 32'd8);

        // Backpressure mid-packet on s1 for 5 cycles.
        do_reset();
        push_pkt(1, 4);
        exp_grant.push_back(1);
        k = 0;
        while (exp_q.size() > 3 && k < 50) begin
            @(negedge clk); #2;
            k++;
        end
        m_ready_want = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            check_val("stall_s1_ready", s_ready[1], 1'b0);
            check_val("stall_m_valid", m_axis_tvalid, 1'b1);
            check_val("stall_tdata", m_axis_tdata, exp_q[0].data);
        end
        m_ready_want = 1'b1;
        wait_done("stall", 100);
        check_val("stall_pkt_count", pkt_count, 32'd1);

        // s3 locked; s0 raised mid-packet must wait for s3's tlast.
        push_pkt(3, 6);
        exp_grant.push_back(3);
        k = 0;
        while (exp_q.size() > 4 && k < 50) begin
            @(negedge clk); #2;
            k++;
        end
        push_pkt(0, 2);
        exp_grant.push_back(0);
        k = 0;
        while (src_q[3].size() > 0 && k < 30) begin
            @(negedge clk); #2;
            check_val("s0_blocked", s_ready[0], 1'b0);
            k++;
        end
        wait_done("no_preempt", 100);
        check_val("no_preempt_pkt_count", pkt_count, 32'd3);

        // Reset during beat 2 of a 4-beat packet, then a clean s1 packet.
        push_pkt(2, 4);
        exp_grant.push_back(2);
        k = 0;
        while (exp_q.size() > 3 && k < 50) begin
            @(negedge clk); #2;
            k++;
        end
        reset = 1'b1;
        flush_all();
        @(negedge clk); #2;
        check_val("midrst_m_valid", m_axis_tvalid, 1'b0);
        check_val("midrst_grant", grant, 2'd3);
        check_val("midrst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_val("midrst_quiet", m_axis_tvalid, 1'b0);
        push_pkt(1, 3);
        exp_grant.push_back(1);
        wait_done("after_rst", 100);
        check_val("after_rst_pkt_count", pkt_count, 32'd1);

        // Counter wrap from all-ones.
        @(negedge clk); #2;
        force dut.pkt_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_count_r;
        check_val("preload", pkt_count, 32'hFFFF_FFFF);
        push_pkt(0, 1);
        exp_grant.push_back(0);
        wait_done("wrap", 100);
        check_val("wrap_pkt_count", pkt_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin : watchdog
        #200000;
        check_val("watchdog", 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "simulation time bound exceeded");
    end

endmodule
